// File: rtl/dff_bist.sv
// Built-in self test for a single async-reset D flop: reset check, LFSR data run with periodic mid-run resets.
// Optional first-mismatch index capture is enabled by defining DFF_BIST_ERR_IDX_EN.
module dff_bist #(
  parameter int unsigned NUM_VEC = 64,
  parameter int unsigned ERR_W   = 8,
  parameter logic [7:0]  SEED    = 8'hA5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             dut_d,
  output logic             dut_rst_n,
  input  logic             dut_q,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt
`ifdef DFF_BIST_ERR_IDX_EN
  ,
  output logic [15:0]      first_err_idx
`endif
);

  localparam int unsigned IDX_W = 16;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RST_CHK = 3'd1;
  localparam logic [2:0] S_RUN     = 3'd2;
  localparam logic [2:0] S_DRAIN   = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam logic [7:0]       SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam logic [IDX_W-1:0] LAST_VEC = IDX_W'(NUM_VEC - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

  logic [2:0]       state, state_nxt;
  logic [IDX_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic [7:0]       lfsr, lfsr_nxt, lfsr_step;
  logic             exp_q, exp_nxt, exp_eff;
  logic             d_nxt, rst_n_nxt, busy_nxt, done_nxt, pass_nxt;
  logic [ERR_W-1:0] err_nxt, err_upd;
  logic             cmp_en, mismatch;
`ifdef DFF_BIST_ERR_IDX_EN
  localparam logic [IDX_W-1:0] RST_CHK_IDX = 16'hFFFE;
  localparam logic [IDX_W-1:0] NO_ERR_IDX  = 16'hFFFF;
  localparam logic [IDX_W-1:0] DRAIN_IDX   = IDX_W'(NUM_VEC);
  logic [IDX_W-1:0] cmp_idx, first_nxt;
`endif

  // Fibonacci LFSR, x^8+x^6+x^5+x^4+1
  assign lfsr_step = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  assign cnt_inc   = cnt + IDX_W'(1);

  // The DUT reset is asynchronous: while it is held low, q must already read 0.
  assign exp_eff  = dut_rst_n ? exp_q : 1'b0;
  assign mismatch = cmp_en && (dut_q != exp_eff);
  assign err_upd  = (mismatch && (err_cnt != ERR_MAX)) ? err_cnt + ERR_W'(1) : err_cnt;

  // Which cycles carry a compare, and their reported index
  always_comb begin
    cmp_en = 1'b0;
`ifdef DFF_BIST_ERR_IDX_EN
    cmp_idx = cnt;
`endif
    case (state)
      S_RST_CHK: begin
        cmp_en = (cnt != '0);
`ifdef DFF_BIST_ERR_IDX_EN
        cmp_idx = RST_CHK_IDX;
`endif
      end
      S_RUN: cmp_en = (cnt != '0);
      S_DRAIN: begin
        cmp_en = 1'b1;
`ifdef DFF_BIST_ERR_IDX_EN
        cmp_idx = DRAIN_IDX;
`endif
      end
      default: cmp_en = 1'b0;
    endcase
  end

  // Next state and next registered outputs
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    lfsr_nxt  = lfsr;
    exp_nxt   = dut_rst_n ? dut_d : 1'b0;
    d_nxt     = 1'b0;
    rst_n_nxt = 1'b0;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
    pass_nxt  = pass;
    err_nxt   = err_upd;
`ifdef DFF_BIST_ERR_IDX_EN
    first_nxt = (mismatch && (err_cnt == '0)) ? cmp_idx : first_err_idx;
`endif
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_RST_CHK;
          cnt_nxt   = '0;
          lfsr_nxt  = SEED_EFF;
          err_nxt   = '0;
          pass_nxt  = 1'b0;
          busy_nxt  = 1'b1;
          d_nxt     = 1'b1;
`ifdef DFF_BIST_ERR_IDX_EN
          first_nxt = NO_ERR_IDX;
`endif
        end
      end
      S_RST_CHK: begin
        busy_nxt = 1'b1;
        if (cnt == '0) begin
          cnt_nxt = IDX_W'(1);
          d_nxt   = 1'b1;
        end else begin
          state_nxt = S_RUN;
          cnt_nxt   = '0;
          d_nxt     = lfsr[0];
          rst_n_nxt = 1'b1;
          lfsr_nxt  = lfsr_step;
        end
      end
      S_RUN: begin
        busy_nxt = 1'b1;
        if (cnt == LAST_VEC) begin
          state_nxt = S_DRAIN;
          rst_n_nxt = 1'b1;
        end else begin
          cnt_nxt   = cnt_inc;
          d_nxt     = lfsr[0];
          rst_n_nxt = (cnt_inc[3:0] != 4'hF);
          lfsr_nxt  = lfsr_step;
        end
      end
      S_DRAIN: begin
        state_nxt = S_DONE;
        done_nxt  = 1'b1;
        pass_nxt  = (err_upd == '0);
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      lfsr      <= SEED_EFF;
      exp_q     <= 1'b0;
      dut_d     <= 1'b0;
      dut_rst_n <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_cnt   <= '0;
`ifdef DFF_BIST_ERR_IDX_EN
      first_err_idx <= NO_ERR_IDX;
`endif
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      lfsr      <= lfsr_nxt;
      exp_q     <= exp_nxt;
      dut_d     <= d_nxt;
      dut_rst_n <= rst_n_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      pass      <= pass_nxt;
      err_cnt   <= err_nxt;
`ifdef DFF_BIST_ERR_IDX_EN
      first_err_idx <= first_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_dff_bist.sv
// Directed bench for dff_bist: ideal, stuck-at and no-reset flop models, abort, ignored starts, saturation.
module tb_dff_bist;

  localparam int unsigned NV = 64;

  logic       clk = 1'b0;
  logic       rst, start, dut_d, dut_rst_n, dut_q, busy, done, pass;
  logic [7:0] err_cnt;
  logic       start2, dut_d2, dut_rst_n2, busy2, done2, pass2;
  logic [1:0] err_cnt2;
`ifdef DFF_BIST_ERR_IDX_EN
  logic [15:0] first_err_idx, first_err_idx2;
`endif

  // mode: 0 ideal async-reset flop, 1 stuck at 0, 2 stuck at 1, 3 flop without reset
  logic [1:0] mode;
  logic       q_async, q_norst;
  logic       d_bits [0:NV-1];
  logic       s_bits [0:NV+7];
  logic [7:0] seed_v;
  int         n_chk, n_pass, cyc, c2;
  logic       saw_done;

  always #5 clk = ~clk;

  always @(posedge clk or negedge dut_rst_n)
    if (!dut_rst_n) q_async <= 1'b0;
    else            q_async <= dut_d;

  always @(posedge clk) q_norst <= dut_d;

  assign dut_q = (mode == 2'd0) ? q_async :
                 (mode == 2'd1) ? 1'b0    :
                 (mode == 2'd2) ? 1'b1    : q_norst;

  dff_bist #(.NUM_VEC(NV), .ERR_W(8), .SEED(8'hA5)) u_dut (
    .clk(clk), .rst(rst), .start(start),
    .dut_d(dut_d), .dut_rst_n(dut_rst_n), .dut_q(dut_q),
    .busy(busy), .done(done), .pass(pass),
`ifdef DFF_BIST_ERR_IDX_EN
    .first_err_idx(first_err_idx),
`endif
    .err_cnt(err_cnt)
  );

  dff_bist #(.NUM_VEC(16), .ERR_W(2)) u_dut_sat (
    .clk(clk), .rst(rst), .start(start2),
    .dut_d(dut_d2), .dut_rst_n(dut_rst_n2), .dut_q(1'b1),
    .busy(busy2), .done(done2), .pass(pass2),
`ifdef DFF_BIST_ERR_IDX_EN
    .first_err_idx(first_err_idx2),
`endif
    .err_cnt(err_cnt2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_run;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Extra start pulses land in RUN, RUN and DRAIN when noisy is set
  task automatic wait_done(input bit noisy, inout int cycles);
    while (done !== 1'b1 && cycles < 300) begin
      start = noisy && (cycles == 5 || cycles == 40 || cycles == 67);
      tick();
      cycles++;
    end
    start = 1'b0;
  endtask

  function automatic logic rst_low(input int i);
    return (i >= 0) && (i < NV) && ((i % 16) == 15);
  endfunction

  // Expected q at compare k (1..NV, NV being the drain compare)
  function automatic logic exp_at(input int k);
    if (rst_low(k) || rst_low(k - 1)) return 1'b0;
    return d_bits[k-1];
  endfunction

  function automatic logic q_at(input int m, input int k);
    if (m == 1) return 1'b0;
    if (m == 2) return 1'b1;
    return d_bits[k-1];
  endfunction

  function automatic int exp_errs(input int m, input int upto);
    int n;
    n = (m == 2 || m == 3) ? 1 : 0;
    for (int k = 1; k <= upto; k++)
      if (q_at(m, k) != exp_at(k)) n++;
    return n;
  endfunction

  initial begin
    n_chk = 0; n_pass = 0;
    rst = 1'b1; start = 1'b0; start2 = 1'b0; mode = 2'd0;
    seed_v = 8'hA5;
    for (int i = 0; i < 8; i++) s_bits[i] = seed_v[7-i];
    for (int n = 0; n < NV; n++)
      s_bits[n+8] = s_bits[n] ^ s_bits[n+2] ^ s_bits[n+3] ^ s_bits[n+4];
    for (int i = 0; i < NV; i++) d_bits[i] = s_bits[i+7];

    repeat (3) tick();
    check("rst_dut_d", dut_d, 0);
    check("rst_dut_rst_n", dut_rst_n, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_sat_outputs", {dut_d2, dut_rst_n2, busy2, done2, pass2, err_cnt2}, 0);
`ifdef DFF_BIST_ERR_IDX_EN
    check("rst_first_err_idx", first_err_idx, 16'hFFFF);
`endif
    rst = 1'b0;
    tick();

    // Ideal flop
    mode = 2'd0;
    start_run(); cyc = 1;
    check("ideal_busy_after_start", busy, 1);
    check("ideal_rst_chk_drive", {dut_rst_n, dut_d}, 2'b01);
    wait_done(1'b0, cyc);
    check("ideal_cycles", cyc, NV + 4);
    check("ideal_err_cnt", err_cnt, 0);
    check("ideal_pass", pass, 1);
    check("ideal_busy_in_done", busy, 0);
`ifdef DFF_BIST_ERR_IDX_EN
    check("ideal_first_err_idx", first_err_idx, 16'hFFFF);
`endif
    start_run();
    check("done_width", done, 0);
    check("start_in_done_ignored", busy, 0);
    tick();
    check("pass_hold", pass, 1);
    check("idle_drive", {dut_rst_n, dut_d}, 2'b00);

    // Stuck at 0
    mode = 2'd1;
    start_run(); cyc = 1;
    check("start_clears_pass", pass, 0);
    wait_done(1'b0, cyc);
    check("sa0_cycles", cyc, NV + 4);
    check("sa0_err_cnt", err_cnt, exp_errs(1, NV));
    check("sa0_pass", pass, 0);
`ifdef DFF_BIST_ERR_IDX_EN
    check("sa0_first_err_idx", first_err_idx, 16'd1);
`endif
    tick();

    // Flop without reset
    mode = 2'd3;
    start_run(); cyc = 1;
    check("start_clears_err_cnt", err_cnt, 0);
`ifdef DFF_BIST_ERR_IDX_EN
    check("start_sets_first_err_idx", first_err_idx, 16'hFFFF);
`endif
    wait_done(1'b0, cyc);
    check("norst_cycles", cyc, NV + 4);
    check("norst_err_cnt", err_cnt, exp_errs(3, NV));
    check("norst_pass", pass, 0);
`ifdef DFF_BIST_ERR_IDX_EN
    check("norst_first_err_idx", first_err_idx, 16'hFFFE);
`endif
    tick();

    // Abort at RUN index 20, checking the vector stream on the way
    mode = 2'd1;
    start_run();
    tick(); tick();
    for (int i = 0; i <= 20; i++) begin
      check($sformatf("vec_d[%0d]", i), dut_d, d_bits[i]);
      check($sformatf("vec_rst_n[%0d]", i), dut_rst_n, !rst_low(i));
      if (i < 20) tick();
    end
    check("abort_err_before", err_cnt, exp_errs(1, 19));
    check("abort_busy_before", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_dut_rst_n", dut_rst_n, 0);
    check("abort_err_cnt", err_cnt, 0);
    check("abort_done", done, 0);
    saw_done = 1'b0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (done) saw_done = 1'b1;
    end
    check("abort_no_done", saw_done, 0);

    // Clean run after abort with stray start pulses
    mode = 2'd0;
    start_run(); cyc = 1;
    wait_done(1'b1, cyc);
    check("noisy_cycles", cyc, NV + 4);
    check("noisy_err_cnt", err_cnt, 0);
    check("noisy_pass", pass, 1);
`ifdef DFF_BIST_ERR_IDX_EN
    check("noisy_first_err_idx", first_err_idx, 16'hFFFF);
`endif
    tick();

    // Start coincident with reset
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    check("rst_start_busy", busy, 0);
    tick();
    check("rst_start_busy_later", busy, 0);
    check("rst_start_pass", pass, 0);

    // Saturating 2-bit counter, q stuck at 1
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    c2 = 1;
    while (done2 !== 1'b1 && c2 < 100) begin
      tick();
      c2++;
    end
    check("sat_cycles", c2, 20);
    check("sat_err_cnt", err_cnt2, 3);
    check("sat_pass", pass2, 0);
`ifdef DFF_BIST_ERR_IDX_EN
    check("sat_first_err_idx", first_err_idx2, 16'hFFFE);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
